// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word type, RAM handshake states, arbiter grant states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for the icache/dcache pair with fixed dcache priority.
// Optional starvation guard for the icache is enabled by defining ARB_STARVE_GUARD_EN.
//
// state | meaning
// IDLE  | nothing granted, RAM outputs quiet
// IGNT  | icache owns the RAM port
// DGNT  | dcache owns the RAM port
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  word_t       iaddr,
    output logic        iwait,
    output word_t       iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  word_t       daddr,
    input  word_t       dstore,
    output logic        dwait,
    output word_t       dload,
    output logic        ramREN,
    output logic        ramWEN,
    output word_t       ramaddr,
    output word_t       ramstore,
    input  word_t       ramload,
    input  logic [1:0]  ramstate,
    output logic        ramerr
);

    arb_state_t state_q, state_d;
    logic       ramerr_q, ramerr_d;
    logic       force_i;
    logic       d_req;
    ramstate_t  rs;

    assign rs    = ramstate_t'(ramstate);
    assign d_req = dREN | dWEN;

    function automatic arb_state_t arb(input logic dreq, input logic ireq, input logic frc);
        if (dreq && !frc)
            return DGNT;
        else if (ireq)
            return IGNT;
        else
            return IDLE;
    endfunction

`ifdef ARB_STARVE_GUARD_EN
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!iREN)
            starve_cnt_d = '0;
        else if (state_q == IGNT && rs == ACCESS)
            starve_cnt_d = '0;
        else if (state_q == DGNT && d_req && rs == ACCESS && starve_cnt_q < CNT_W'(STARVE_LIMIT))
            starve_cnt_d = starve_cnt_q + 1'b1;
    end

    // Compare the updated count so the grant decided in the same ACCESS cycle
    // that completes the LIMIT-th dcache transfer already goes to the icache.
    assign force_i = iREN && (starve_cnt_d == CNT_W'(STARVE_LIMIT));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            starve_cnt_q <= '0;
        else
            starve_cnt_q <= starve_cnt_d;
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{STARVE_LIMIT[0], CNT_W[0]};
    assign force_i    = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        ramerr_d = ramerr_q;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (state_q)
            IDLE: state_d = arb(d_req, iREN, force_i);
            IGNT: begin
                if (!iREN) begin
                    state_d = IDLE;
                end else if (rs == ACCESS) begin
                    iwait   = 1'b0;
                    state_d = arb(d_req, iREN, force_i);
                end else if (rs == ERROR) begin
                    ramerr_d = 1'b1;
                end
            end
            DGNT: begin
                if (!d_req) begin
                    state_d = IDLE;
                end else if (rs == ACCESS) begin
                    dwait   = 1'b0;
                    state_d = arb(d_req, iREN, force_i);
                end else if (rs == ERROR) begin
                    ramerr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            ramerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ramerr_q <= ramerr_d;
        end
    end

    // A simultaneous read and write from the dcache is a write.
    assign ramREN = (state_q == IGNT && iREN) || (state_q == DGNT && dREN && !dWEN);
    assign ramWEN = (state_q == DGNT) && dWEN;

    always_comb begin
        case (state_q)
            IGNT:    ramaddr = iaddr;
            DGNT:    ramaddr = daddr;
            default: ramaddr = '0;
        endcase
    end

    assign ramstore = (state_q == DGNT) ? dstore : '0;
    assign iload    = ramload;
    assign dload    = ramload;
    assign ramerr   = ramerr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: ownership-level reference model plus directed scenarios.
module tb_mem_arbiter;

    localparam logic [1:0] RS_FREE = 2'd0;
    localparam logic [1:0] RS_BUSY = 2'd1;
    localparam logic [1:0] RS_ACC  = 2'd2;
    localparam logic [1:0] RS_ERR  = 2'd3;
    localparam int         LIMIT   = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload = 32'hA5A5_0001;
    logic [1:0]  ramstate = RS_FREE;
    logic        ramerr;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .ramerr(ramerr)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who owns the RAM port (0 none, 1 icache, 2 dcache),
    // how many dcache transfers completed in a row while the icache waited, sticky error.
    int owner  = 0;
    int streak = 0;
    bit err    = 1'b0;

    function automatic int pick(input bit guard_now);
        if ((dREN || dWEN) && !guard_now) return 2;
        if (iREN) return 1;
        return 0;
    endfunction

    bit m_iact, m_dact, m_guard;
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            owner  = 0;
            streak = 0;
            err    = 1'b0;
        end else begin
            m_iact = (owner == 1) && iREN;
            m_dact = (owner == 2) && (dREN || dWEN);
            if (!iREN) streak = 0;
            else if (m_iact && ramstate == RS_ACC) streak = 0;
            else if (m_dact && ramstate == RS_ACC && streak < LIMIT) streak = streak + 1;
`ifdef ARB_STARVE_GUARD_EN
            m_guard = iREN && (streak == LIMIT);
`else
            m_guard = 1'b0;
`endif
            if (owner == 0) owner = pick(m_guard);
            else if (!(m_iact || m_dact)) owner = 0;
            else if (ramstate == RS_ACC) owner = pick(m_guard);
            else if (ramstate == RS_ERR) err = 1'b1;
        end
    end

    always @(negedge CLK) begin
        logic        e_iwait, e_dwait, e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        e_iwait = !((owner == 1) && iREN && ramstate == RS_ACC);
        e_dwait = !((owner == 2) && (dREN || dWEN) && ramstate == RS_ACC);
        e_ren   = ((owner == 1) && iREN) || ((owner == 2) && dREN && !dWEN);
        e_wen   = (owner == 2) && dWEN;
        e_addr  = (owner == 1) ? iaddr : (owner == 2) ? daddr : 32'h0;
        e_store = (owner == 2) ? dstore : 32'h0;
        check("m_iwait",    {31'b0, iwait},  {31'b0, e_iwait});
        check("m_dwait",    {31'b0, dwait},  {31'b0, e_dwait});
        check("m_ramREN",   {31'b0, ramREN}, {31'b0, e_ren});
        check("m_ramWEN",   {31'b0, ramWEN}, {31'b0, e_wen});
        check("m_ramaddr",  ramaddr,  e_addr);
        check("m_ramstore", ramstore, e_store);
        check("m_iload",    iload,    ramload);
        check("m_dload",    dload,    ramload);
        check("m_ramerr",   {31'b0, ramerr}, {31'b0, err});
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_all();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = RS_FREE;
        repeat (3) step();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int dg;
        bit ig;

        // 1: reset held with an icache request pending
        iREN  = 1'b1;
        iaddr = 32'h40;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("t1 iwait",  {31'b0, iwait},  32'd1);
        check("t1 dwait",  {31'b0, dwait},  32'd1);
        check("t1 ramREN", {31'b0, ramREN}, 32'd0);
        check("t1 ramerr", {31'b0, ramerr}, 32'd0);
        #1;
        nRST = 1'b1;
        iREN = 1'b0;

        // 2: icache read, two BUSY cycles then ACCESS
        step();
        iREN = 1'b1; iaddr = 32'h40; ramstate = RS_BUSY; ramload = 32'h1234_5678;
        step();
        @(negedge CLK);
        check("t2 ramaddr c1", ramaddr, 32'h40);
        check("t2 ramREN c1",  {31'b0, ramREN}, 32'd1);
        check("t2 iwait c1",   {31'b0, iwait},  32'd1);
        step();
        step();
        ramstate = RS_ACC;
        @(negedge CLK);
        check("t2 iwait c3", {31'b0, iwait}, 32'd0);
        check("t2 iload c3", iload, 32'h1234_5678);
        idle_all();

        // 3: simultaneous icache read and dcache read+write; dcache wins, write dominates
        step();
        iREN = 1'b1; iaddr = 32'h44;
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEAD_BEEF;
        ramstate = RS_ACC;
        step();
        @(negedge CLK);
        check("t3 ramWEN",   {31'b0, ramWEN}, 32'd1);
        check("t3 ramREN",   {31'b0, ramREN}, 32'd0);
        check("t3 ramaddr",  ramaddr,  32'h80);
        check("t3 ramstore", ramstore, 32'hDEAD_BEEF);
        check("t3 dwait",    {31'b0, dwait},  32'd0);
        step();
        dREN = 1'b0; dWEN = 1'b0;
        step();
        step();
        @(negedge CLK);
        check("t3 i ramREN",  {31'b0, ramREN}, 32'd1);
        check("t3 i ramaddr", ramaddr, 32'h44);
        check("t3 i iwait",   {31'b0, iwait},  32'd0);
        idle_all();

        // 4: dcache held busy with icache pending, RAM always ready
        step();
        iREN = 1'b1; iaddr = 32'h200; dREN = 1'b1; daddr = 32'h300; ramstate = RS_ACC;
        dg = 0;
        ig = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            @(negedge CLK);
            if (!dwait) dg++;
            if (!iwait) begin
                ig = 1'b1;
                break;
            end
        end
`ifdef ARB_STARVE_GUARD_EN
        check("t4 d grants before i", dg, 32'd4);
        check("t4 i granted", {31'b0, ig}, 32'd1);
`else
        check("t4 d grants", dg, 32'd10);
        check("t4 i starved", {31'b0, ig}, 32'd0);
`endif
        idle_all();

        // 5: ERROR for one cycle during a dcache grant, then ACCESS
        step();
        dREN = 1'b1; daddr = 32'h100; ramstate = RS_FREE; ramload = 32'h0BAD_F00D;
        step();
        ramstate = RS_ERR;
        @(negedge CLK);
        check("t5 dwait on ERROR", {31'b0, dwait}, 32'd1);
        step();
        ramstate = RS_ACC;
        @(negedge CLK);
        check("t5 ramerr set", {31'b0, ramerr}, 32'd1);
        check("t5 dwait",      {31'b0, dwait},  32'd0);
        check("t5 dload",      dload, 32'h0BAD_F00D);
        idle_all();
        @(negedge CLK);
        check("t5 ramerr sticky", {31'b0, ramerr}, 32'd1);

        // 6: reset pulsed in the middle of a dcache grant
        step();
        dREN = 1'b1; daddr = 32'h500; ramstate = RS_BUSY;
        step();
        @(negedge CLK);
        check("t6 ramREN before", {31'b0, ramREN}, 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        check("t6 ramREN async", {31'b0, ramREN}, 32'd0);
        check("t6 ramWEN async", {31'b0, ramWEN}, 32'd0);
        check("t6 dwait async",  {31'b0, dwait},  32'd1);
        check("t6 ramerr clear", {31'b0, ramerr}, 32'd0);
        dREN = 1'b0;
        @(negedge CLK);
        #1;
        nRST = 1'b1;
        step();
        @(negedge CLK);
        check("t6 ramREN idle",  {31'b0, ramREN}, 32'd0);
        check("t6 ramaddr idle", ramaddr, 32'h0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
